sum_arbiter: RTL and testbench

Shares one 7-bit ripple adder (`struk_sum` instance, internal) between two requesters. Round-robin arbitration, a registered operand/result path and a one-cycle done strobe. Sits between the lab datapath clients and the adder, so both clients get a synchronous, handshaked add service without duplicating the adder.

---
 rtl/sum_arbiter.sv | 118 +++++++++++
 tb/tb_sum_arbiter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/sum_arbiter.sv
// Two-requester round-robin front end for a shared ripple adder.
// One operation is in flight at a time: IDLE -> CALC -> DONE -> IDLE.

module struk_sum #(
  parameter int W = 7
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic         co
);
  logic [W:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < W; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign co = c[W];
endmodule

module sum_arbiter #(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0,
  input  logic [W-1:0] a0,
  input  logic [W-1:0] b0,
  input  logic         ci0,
  input  logic         req1,
  input  logic [W-1:0] a1,
  input  logic [W-1:0] b1,
  input  logic         ci1,
  output logic         gnt0,
  output logic         gnt1,
  output logic         busy,
  output logic         done,
  output logic         done_id,
  output logic [W-1:0] res,
  output logic         co
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t       state, state_next;
  logic         last, owner;
  logic [W-1:0] op_a, op_b;
  logic         op_ci;
  logic         any_req, winner;
  logic [W-1:0] sum;
  logic         sum_co;

  struk_sum #(.W(W)) u_adder (
    .a  (op_a),
    .b  (op_b),
    .ci (op_ci),
    .s  (sum),
    .co (sum_co)
  );

  // On a tie the requester not served last wins; otherwise the lone requester.
  assign any_req = req0 | req1;
  assign winner  = (req0 & req1) ? ~last : req1;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (any_req) state_next = CALC;
      CALC:    state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    gnt0 = (state == CALC) && !owner;
    gnt1 = (state == CALC) && owner;
    busy = (state != IDLE);
    done = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last    <= 1'b1;
      owner   <= 1'b0;
      op_a    <= '0;
      op_b    <= '0;
      op_ci   <= 1'b0;
      res     <= '0;
      co      <= 1'b0;
      done_id <= 1'b0;
    end else begin
      case (state)
        IDLE: if (any_req) begin
          owner <= winner;
          op_a  <= winner ? a1 : a0;
          op_b  <= winner ? b1 : b0;
          op_ci <= winner ? ci1 : ci0;
        end
        CALC: begin
          res     <= sum;
          co      <= sum_co;
          done_id <= owner;
          last    <= owner;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_sum_arbiter.sv
// Bench for sum_arbiter: transaction-level reference model feeding a scoreboard,
// directed scenarios followed by randomized request traffic.

module tb_sum_arbiter;
  localparam int W = 7;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req0 = 1'b0, req1 = 1'b0;
  logic [W-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic         ci0 = 1'b0, ci1 = 1'b0;
  logic         gnt0, gnt1, busy, done, done_id, co;
  logic [W-1:0] res;

  sum_arbiter #(.W(W)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .a0(a0), .b0(b0), .ci0(ci0),
    .req1(req1), .a1(a1), .b1(b1), .ci1(ci1),
    .gnt0(gnt0), .gnt1(gnt1), .busy(busy), .done(done),
    .done_id(done_id), .res(res), .co(co)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a request seen while the adder is free is served;
  // the adder is then unavailable for the next two edges.
  logic [8:0] exp_q[$];   // {id, co, res}
  int         exp_cyc_q[$];
  logic       gnt_q[$];
  int         gnt_cyc_q[$];
  int         cyc = 0;
  int         m_wait = 0;
  logic       m_last = 1'b1;
  logic       rst_edge = 1'b0;

  always @(posedge clk) begin
    logic       w;
    logic [7:0] s8;
    cyc++;
    if (rst) begin
      m_wait = 0;
      m_last = 1'b1;
      rst_edge = 1'b1;
      exp_q.delete(); exp_cyc_q.delete(); gnt_q.delete(); gnt_cyc_q.delete();
    end else begin
      rst_edge = 1'b0;
      if (m_wait > 0) m_wait--;
      else if (req0 || req1) begin
        w = (req0 && req1) ? !m_last : req1;
        s8 = w ? (8'(a1) + 8'(b1) + 8'(ci1)) : (8'(a0) + 8'(b0) + 8'(ci0));
        exp_q.push_back({w, s8});
        exp_cyc_q.push_back(cyc + 1);
        gnt_q.push_back(w);
        gnt_cyc_q.push_back(cyc);
        m_last = w;
        m_wait = 2;
      end
    end
  end

  // Monitor: compares DUT outputs against the model between clock edges.
  logic       mon_en = 1'b0;
  logic [8:0] hold = '0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (rst_edge) begin
        check("reset_outputs", {25'd0, gnt0, gnt1, busy, done, done_id, co, 1'b0} | 32'(res), 32'd0);
        hold = '0;
      end
      check("busy", busy, (m_wait != 0));
      if (gnt0 || gnt1) begin
        check("gnt_exclusive", gnt0 & gnt1, 1'b0);
        if (gnt_q.size() == 0) check("gnt_unexpected", 1'b1, 1'b0);
        else begin
          check("gnt_id", gnt1, gnt_q.pop_front());
          check("gnt_cycle", cyc, gnt_cyc_q.pop_front());
        end
      end
      if (done) begin
        if (exp_q.size() == 0) check("done_unexpected", 1'b1, 1'b0);
        else begin
          hold = exp_q.pop_front();
          check("done_result", {done_id, co, res}, hold);
          check("done_cycle", cyc, exp_cyc_q.pop_front());
        end
      end else if (!rst_edge) begin
        check("result_hold", {done_id, co, res}, hold);
      end
    end
  end

  task automatic set_req(input logic r0, input logic [W-1:0] x0, input logic [W-1:0] y0, input logic c0,
                         input logic r1, input logic [W-1:0] x1, input logic [W-1:0] y1, input logic c1);
    req0 = r0; a0 = x0; b0 = y0; ci0 = c0;
    req1 = r1; a1 = x1; b1 = y1; ci1 = c1;
  endtask

  // Holds one request until its grant is visible, then drops it.
  task automatic issue(input logic id, input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    bit seen = 0;
    if (id) begin req1 = 1; a1 = x; b1 = y; ci1 = c; end
    else    begin req0 = 1; a0 = x; b0 = y; ci0 = c; end
    for (int i = 0; i < 8 && !seen; i++) begin
      @(negedge clk);
      if (id ? gnt1 : gnt0) seen = 1;
    end
    if (!seen) begin
      checks++; failures++;
      $display("FAIL issue_timeout actual=no_grant required=gnt%0d", id);
    end
    if (id) req1 = 0; else req0 = 0;
  endtask

  task automatic expect_done(input string nm, input int r, input int c, input int id);
    bit seen = 0;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1;
        check(nm, {done_id, co, res}, {id[0], c[0], r[6:0]});
      end
    end
    if (!seen) begin
      checks++; failures++;
      $display("FAIL %s_timeout actual=no_done required=done", nm);
    end
  endtask

  task automatic do_reset();
    rst = 1;
    @(negedge clk);
    rst = 0;
  endtask

  initial begin
    int ndone;
    repeat (2) @(negedge clk);
    mon_en = 1;
    @(negedge clk);
    rst = 0;

    // Single add on requester 0
    issue(0, 7'b0000101, 7'b0001010, 0);
    expect_done("single_add", 7'b0001111, 0, 0);
    @(negedge clk);
    check("busy_after_done", busy, 1'b0);

    // Overflow with carry-in on requester 1
    issue(1, 7'b1111111, 7'b1111111, 1);
    expect_done("overflow_ci", 7'b1111111, 1, 1);
    repeat (2) @(negedge clk);

    // Simultaneous first requests after reset
    do_reset();
    set_req(1, 7'b0000001, 7'b0000010, 0, 1, 7'b0011001, 7'b0001010, 0);
    expect_done("tie_first", 7'b0000011, 0, 0);
    expect_done("tie_second", 7'b0100011, 0, 1);
    set_req(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);

    // Sustained contention for 12 cycles
    ndone = 0;
    set_req(1, 7'($urandom), 7'($urandom), 1'($urandom), 1, 7'($urandom), 7'($urandom), 1'($urandom));
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) ndone++;
      a0 = 7'($urandom); a1 = 7'($urandom);
    end
    set_req(0, 0, 0, 0, 0, 0, 0, 0);
    check("contention_done_count", ndone, 4);
    repeat (4) @(negedge clk);

    // Operand change right after grant
    issue(0, 7'b0101010, 7'b0000001, 1);
    a0 = 7'b1110000;
    expect_done("operand_change", 7'b0101100, 0, 0);
    repeat (2) @(negedge clk);

    // Reset while in CALC, then a tie must favour requester 0
    req0 = 1; a0 = 7'd9; b0 = 7'd9;
    @(negedge clk);
    check("reset_mid_calc_state", {gnt0, busy}, 2'b11);
    rst = 1; req0 = 0;
    @(negedge clk);
    rst = 0;
    repeat (3) @(negedge clk);
    set_req(1, 7'd3, 7'd4, 0, 1, 7'd100, 7'd27, 1);
    expect_done("tie_after_reset", 7'd7, 0, 0);
    set_req(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (4) @(negedge clk);

    // Randomized traffic, with an occasional reset
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 3) == 0) req0 = ~req0;
      if ($urandom_range(0, 3) == 0) req1 = ~req1;
      a0 = 7'($urandom); b0 = 7'($urandom); ci0 = 1'($urandom);
      a1 = 7'($urandom); b1 = 7'($urandom); ci1 = 1'($urandom);
      rst = ($urandom_range(0, 99) == 0);
    end
    @(negedge clk);
    rst = 0;
    set_req(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (6) @(negedge clk);
    check("queue_drained", exp_q.size() + gnt_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
